// File: rtl/mux_channel_scanner_pkg.sv
// Shared constants, FSM state type and slot helpers for the mux channel scanner.
package mux_scan_pkg;

   localparam int unsigned NCH    = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned DATA_W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // LSB position of channel n inside the packed snapshot
   function automatic int unsigned slot_lo(input int unsigned n);
      return n * DATA_W;
   endfunction

endpackage

// File: rtl/mux_channel_scanner_next_finder.sv
// Combinational search over a channel mask: lowest set bit and next set bit above cur.
module scan_next_finder
   import mux_scan_pkg::*;
(
   input  logic [NCH-1:0]   mask,
   input  logic [SEL_W-1:0] cur,
   output logic [SEL_W-1:0] next_idx,
   output logic             has_next,
   output logic [SEL_W-1:0] first_idx,
   output logic             any
);

   // Scan downwards so the lowest qualifying bit is the one left standing
   always_comb begin
      next_idx  = '0;
      has_next  = 1'b0;
      first_idx = '0;
      any       = |mask;
      for (int i = int'(NCH) - 1; i >= 0; i--) begin
         if (mask[i]) begin
            first_idx = SEL_W'(i);
         end
         if (mask[i] && (i > int'(cur))) begin
            next_idx = SEL_W'(i);
            has_next = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_channel_scanner.sv
// Drives the 8:1 mux select over enabled channels, dwells, captures mux_y into
// a sample strobe and a per-channel snapshot; single-frame or continuous.
module mux_channel_scanner
   import mux_scan_pkg::*;
#(
   parameter int unsigned DWELL = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    continuous,
   input  logic [NCH-1:0]          ch_mask,
   output logic [SEL_W-1:0]        sel,
   input  logic [DATA_W-1:0]       mux_y,
   output logic                    sample_valid,
   output logic [SEL_W-1:0]        sample_ch,
   output logic [DATA_W-1:0]       sample_data,
   output logic                    frame_done,
   output logic                    busy,
   output logic [NCH*DATA_W-1:0]   snapshot
);

   localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

   state_t                  state, state_d;
   logic [CNT_W-1:0]        cnt, cnt_d;
   logic [NCH-1:0]          mask_q, mask_d;
   logic [SEL_W-1:0]        sel_d;
   logic                    sample_valid_d;
   logic [SEL_W-1:0]        sample_ch_d;
   logic [DATA_W-1:0]       sample_data_d;
   logic                    frame_done_d;
   logic                    busy_d;
   logic [NCH*DATA_W-1:0]   snapshot_d;

   logic [SEL_W-1:0]        q_next, q_first, c_next, c_first;
   logic                    q_has, q_any, c_has, c_any;
   logic                    unused_finder;

   // Next enabled channel within the latched frame mask
   scan_next_finder u_frame_finder (
      .mask      (mask_q),
      .cur       (sel),
      .next_idx  (q_next),
      .has_next  (q_has),
      .first_idx (q_first),
      .any       (q_any)
   );

   // First enabled channel of the live mask, used at frame start and wrap
   scan_next_finder u_start_finder (
      .mask      (ch_mask),
      .cur       (sel),
      .next_idx  (c_next),
      .has_next  (c_has),
      .first_idx (c_first),
      .any       (c_any)
   );

   assign unused_finder = ^{q_first, q_any, c_next, c_has};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sel          <= '0;
         cnt          <= '0;
         mask_q       <= '0;
         sample_valid <= 1'b0;
         sample_ch    <= '0;
         sample_data  <= '0;
         frame_done   <= 1'b0;
         busy         <= 1'b0;
         snapshot     <= '0;
      end else begin
         state        <= state_d;
         sel          <= sel_d;
         cnt          <= cnt_d;
         mask_q       <= mask_d;
         sample_valid <= sample_valid_d;
         sample_ch    <= sample_ch_d;
         sample_data  <= sample_data_d;
         frame_done   <= frame_done_d;
         busy         <= busy_d;
         snapshot     <= snapshot_d;
      end
   end

   always_comb begin
      state_d        = state;
      sel_d          = sel;
      cnt_d          = cnt;
      mask_d         = mask_q;
      sample_valid_d = 1'b0;
      sample_ch_d    = sample_ch;
      sample_data_d  = sample_data;
      frame_done_d   = 1'b0;
      snapshot_d     = snapshot;

      case (state)
         IDLE: begin
            if (start && c_any) begin
               mask_d  = ch_mask;
               sel_d   = c_first;
               cnt_d   = CNT_LOAD;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (cnt != '0) begin
               cnt_d = cnt - CNT_W'(1);
            end else begin
               // Capture edge: strobe the sample and update its snapshot slot
               sample_valid_d = 1'b1;
               sample_ch_d    = sel;
               sample_data_d  = mux_y;
               for (int n = 0; n < int'(NCH); n++) begin
                  if (sel == SEL_W'(n)) begin
                     snapshot_d[slot_lo(n) +: DATA_W] = mux_y;
                  end
               end
               if (q_has) begin
                  sel_d = q_next;
                  cnt_d = CNT_LOAD;
               end else begin
                  frame_done_d = 1'b1;
                  if (continuous && c_any) begin
                     mask_d = ch_mask;
                     sel_d  = c_first;
                     cnt_d  = CNT_LOAD;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SCAN);
   end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Self-checking bench: three scanners (DWELL 4/2/1) against a frame-level reference model.
module tb_mux_channel_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        cont;
   logic [7:0]  mask;
   logic [3:0]  off;
   int          which;

   logic [2:0]  sel_o [3];
   logic [3:0]  my    [3];
   logic        st    [3];
   logic        sv    [3];
   logic [2:0]  sc    [3];
   logic [3:0]  sd    [3];
   logic        fd    [3];
   logic        bz    [3];
   logic [31:0] snap  [3];

   int          dw [3] = '{4, 2, 1};

   int          vectors = 0;
   int          miscompares = 0;

   logic [12:0] obs  [$];
   logic [12:0] expq [$];
   int          last_sel  [3];
   int          last_ch   [3];
   logic [3:0]  last_data [3];
   logic [31:0] snap_m    [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      assign st[g] = start && (which == g);
      assign my[g] = 4'(sel_o[g]) + off;
      mux_channel_scanner #(.DWELL(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
         .clk          (clk),
         .rst          (rst),
         .start        (st[g]),
         .continuous   (cont),
         .ch_mask      (mask),
         .sel          (sel_o[g]),
         .mux_y        (my[g]),
         .sample_valid (sv[g]),
         .sample_ch    (sc[g]),
         .sample_data  (sd[g]),
         .frame_done   (fd[g]),
         .busy         (bz[g]),
         .snapshot     (snap[g])
      );
   end

   function automatic void model_reset();
      for (int g = 0; g < 3; g++) begin
         last_sel[g]  = 0;
         last_ch[g]   = 0;
         last_data[g] = '0;
         snap_m[g]    = '0;
      end
   endfunction

   // Expected per-cycle {busy,sel,valid,ch,data,done} for nf frames starting at c=0
   function automatic void build_exp(input int g, input logic [7:0] m, input int nf, input int ncyc);
      int chl[$];
      int d, k, l, ch, nfr;
      logic busy_e, v, f;
      d = dw[g];
      for (int n = 0; n < 8; n++) if (m[n]) chl.push_back(n);
      k   = chl.size();
      nfr = (k == 0) ? 0 : nf;
      l   = k * d;
      expq.delete();
      for (int c = 0; c < ncyc; c++) begin
         busy_e = (nfr > 0) && (c < nfr * l);
         if (busy_e) last_sel[g] = chl[(c % l) / d];
         v = (nfr > 0) && (c > 0) && (c <= nfr * l) && (c % d == 0);
         f = 1'b0;
         if (v) begin
            ch           = chl[((c - 1) % l) / d];
            last_ch[g]   = ch;
            last_data[g] = 4'(ch) + off;
            snap_m[g][ch*4 +: 4] = last_data[g];
            f = (c % l == 0);
         end
         expq.push_back({busy_e, 3'(last_sel[g]), v, 3'(last_ch[g]), last_data[g], f});
      end
   endfunction

   // Drive one scan on instance g and record per-cycle outputs (c=0 is just after the start edge)
   task automatic run_scan(input int g, input bit do_start, input int ncyc,
                           input int drop_at, input int restart_at, input bit scramble);
      which = g;
      obs.delete();
      @(negedge clk);
      start = do_start;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         obs.push_back({bz[g], sel_o[g], sv[g], sc[g], sd[g], fd[g]});
         if (c == 0) start = 1'b0;
         if (c == drop_at) cont = 1'b0;
         if (c == restart_at) start = 1'b1;
         if (c == restart_at + 1) start = 1'b0;
         if (scramble) mask = 8'($urandom);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         vectors++;
         if ({sel_o[g], sv[g], sc[g], sd[g], fd[g], bz[g], snap[g]} !== 45'd0) begin
            miscompares++;
            $display("FAIL reset inst %0d: got sel=%0d v=%b ch=%0d d=%0d fd=%b busy=%b snap=%h, expected all 0",
                     g, sel_o[g], sv[g], sc[g], sd[g], fd[g], bz[g], snap[g]);
         end
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_full_frame();
      off = 4'd3; mask = 8'hFF; cont = 1'b0;
      run_scan(0, 1'b1, 36, -1, -1, 1'b0);
      build_exp(0, 8'hFF, 1, 36);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL full_frame cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
      vectors++;
      if (snap[0] !== 32'hA9876543) begin
         miscompares++;
         $display("FAIL full_frame_snapshot: got %h expected a9876543", snap[0]);
      end
   endtask

   task automatic test_sparse_mask();
      mask = 8'b1010_0100; cont = 1'b0;
      run_scan(1, 1'b1, 9, -1, -1, 1'b0);
      build_exp(1, 8'b1010_0100, 1, 9);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL sparse_mask cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
      vectors++;
      if (snap[1] !== snap_m[1]) begin
         miscompares++;
         $display("FAIL sparse_snapshot: got %h expected %h", snap[1], snap_m[1]);
      end
   endtask

   task automatic test_continuous();
      mask = 8'h81; cont = 1'b1;
      run_scan(0, 1'b1, 30, 17, -1, 1'b0);
      build_exp(0, 8'h81, 3, 30);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL continuous cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
      cont = 1'b0;
   endtask

   task automatic test_zero_mask();
      mask = 8'h00; cont = 1'b0;
      run_scan(0, 1'b1, 10, -1, -1, 1'b0);
      build_exp(0, 8'h00, 1, 10);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL zero_mask cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [7:0] m;
      m = 8'($urandom) | 8'h10;
      mask = m; cont = 1'b0;
      run_scan(0, 1'b1, 36, -1, 5, 1'b0);
      build_exp(0, m, 1, 36);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL start_while_busy cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
   endtask

   task automatic test_back_to_back();
      mask = 8'h0F; cont = 1'b0;
      run_scan(2, 1'b1, 7, -1, -1, 1'b0);
      build_exp(2, 8'h0F, 1, 7);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL back_to_back cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      off = 4'd3; mask = 8'hFF; cont = 1'b0; which = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (13) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({sel_o[0], sv[0], sc[0], sd[0], fd[0], bz[0], snap[0]} !== 45'd0) begin
         miscompares++;
         $display("FAIL async_reset: got sel=%0d v=%b ch=%0d d=%0d fd=%b busy=%b snap=%h, expected all 0",
                  sel_o[0], sv[0], sc[0], sd[0], fd[0], bz[0], snap[0]);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_scan(0, 1'b0, 8, -1, -1, 1'b0);
      build_exp(0, 8'hFF, 0, 8);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL post_reset_idle cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
      run_scan(0, 1'b1, 34, -1, -1, 1'b0);
      build_exp(0, 8'hFF, 1, 34);
      for (int c = 0; c < obs.size(); c++) begin
         vectors++;
         if (obs[c] !== expq[c]) begin
            miscompares++;
            $display("FAIL post_reset_rescan cyc %0d: got %h expected %h", c, obs[c], expq[c]);
         end
      end
   endtask

   task automatic test_random();
      int g, k;
      logic [7:0] m;
      for (int it = 0; it < 8; it++) begin
         g    = int'($urandom_range(0, 2));
         m    = 8'($urandom_range(1, 255));
         off  = 4'($urandom);
         mask = m; cont = 1'b0;
         k    = $countones(m);
         run_scan(g, 1'b1, k * dw[g] + 3, -1, -1, 1'b1);
         build_exp(g, m, 1, k * dw[g] + 3);
         for (int c = 0; c < obs.size(); c++) begin
            vectors++;
            if (obs[c] !== expq[c]) begin
               miscompares++;
               $display("FAIL random it %0d inst %0d mask %h cyc %0d: got %h expected %h",
                        it, g, m, c, obs[c], expq[c]);
            end
         end
         vectors++;
         if (snap[g] !== snap_m[g]) begin
            miscompares++;
            $display("FAIL random_snapshot it %0d inst %0d: got %h expected %h", it, g, snap[g], snap_m[g]);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cont = 1'b0; mask = '0; off = 4'd3; which = 0;
      model_reset();
      test_reset();
      test_full_frame();
      test_sparse_mask();
      test_continuous();
      test_zero_mask();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_scan();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
